// File: rtl/ifu_pkg.sv
// Shared constants, FSM state type and helpers for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_STALL = 1'b1
  } fetch_state_e;

  // Big-endian assembly: earlier bytes migrate toward bit 31 as later ones arrive.
  function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] word,
                                                      input logic [7:0]        b);
    return {word[WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, datapath handshake and redirect signals of the fetch unit.
// master: the fetch unit side; slave: memory/datapath side.
interface instr_fetch_unit_if
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_rd, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_rd, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush, registered count and combinational head.
module ifu_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         valid_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so the head reads zero before any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads byte-wide instruction memory, assembles big-endian
// 32-bit words, buffers them with their PC and hands them out over valid/ready.
// Redirects flush buffered words, the partial word and any in-flight read.
// Optional: define IFU_STALL_CNT_EN to add the stall_cnt output (cycles where the
// datapath was ready but no word was available, excluding redirect cycles).
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned EntryW = WORD_W + ADDR_W;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              drop_q, drop_d;
  logic              asm_q, asm_d;
  logic [1:0]        cap_cnt_q, cap_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] word_pc_q, word_pc_d;
  logic [WORD_W-1:0] hold_instr_q;
  logic [ADDR_W-1:0] hold_pc_q;

  logic              may_start;
  logic              capture;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] fifo_head;
  logic              fifo_valid;
  logic [CntW-1:0]   fifo_count;

  // Read strobe and byte address follow the fetch state; silent while in reset.
  always_comb begin
    bus.imem_rd   = rst_n && (state_q == S_FETCH);
    bus.imem_addr = fetch_pc_q + ADDR_W'(byte_cnt_q);
  end

  // A new word may start only if its push is guaranteed a free FIFO slot.
  assign may_start = (int'(fifo_count) + int'(asm_q)) < int'(DEPTH);

  // Fetch FSM next-state: byte issue sequencing, stall and redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    if (bus.redirect) begin
      state_d    = S_FETCH;
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(BYTES_PER_WORD);
            byte_cnt_d = '0;
            if (!may_start) state_d = S_STALL;
          end
        end
        S_STALL: begin
          if (may_start) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Capture path: track outstanding reads, shift in returned bytes, push on the 4th.
  always_comb begin
    rd_pend_d = bus.imem_rd;
    // A read issued in a redirect cycle returns data for the abandoned stream.
    drop_d    = bus.redirect && bus.imem_rd;
    capture   = rd_pend_q && !drop_q && !bus.redirect;
    push      = capture && (cap_cnt_q == 2'd3);
    word_d    = word_q;
    cap_cnt_d = cap_cnt_q;
    word_pc_d = word_pc_q;
    asm_d     = asm_q;
    if (capture) begin
      word_d    = shift_in_byte(word_q, bus.imem_rdata);
      cap_cnt_d = cap_cnt_q + 2'd1;
    end
    // Issuing byte 0 of the next word can coincide with pushing the previous one.
    if (bus.imem_rd && (byte_cnt_q == 2'd0)) begin
      asm_d     = 1'b1;
      word_pc_d = fetch_pc_q;
    end else if (push) begin
      asm_d = 1'b0;
    end
    if (bus.redirect) begin
      cap_cnt_d = '0;
      asm_d     = 1'b0;
    end
  end

  // Fetch and assembly state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= '0;
      byte_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      drop_q     <= 1'b0;
      asm_q      <= 1'b0;
      cap_cnt_q  <= '0;
      word_q     <= '0;
      word_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      rd_pend_q  <= rd_pend_d;
      drop_q     <= drop_d;
      asm_q      <= asm_d;
      cap_cnt_q  <= cap_cnt_d;
      word_q     <= word_d;
      word_pc_q  <= word_pc_d;
    end
  end

  // A pop coinciding with a redirect is discarded along with everything else.
  assign pop = fifo_valid && bus.instr_ready && !bus.redirect;

  ifu_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redirect),
    .push_i  (push),
    .wdata_i ({word_d, word_pc_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  // Remember the last presented word so instr/instr_pc stay put while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else if (fifo_valid) begin
      hold_instr_q <= fifo_head[EntryW-1 -: WORD_W];
      hold_pc_q    <= fifo_head[ADDR_W-1:0];
    end
  end

  // Datapath-facing outputs.
  always_comb begin
    bus.instr_valid = fifo_valid;
    bus.instr       = fifo_valid ? fifo_head[EntryW-1 -: WORD_W] : hold_instr_q;
    bus.instr_pc    = fifo_valid ? fifo_head[ADDR_W-1:0] : hold_pc_q;
  end

`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the datapath waited on an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.instr_ready && !fifo_valid && !bus.redirect &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle table after reset plus
// hand-written stall, redirect and wrap sequences with a word scoreboard.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(8)) bus ();

`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch_unit #(
    .ADDR_W (8),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef IFU_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: location i holds i; registered read.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  always @(posedge clk) if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        ready;
    logic        exp_rd;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [7:0]  exp_pc;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] pc);
    logic [7:0] b1, b2, b3;
    b1 = pc + 8'd1;
    b2 = pc + 8'd2;
    b3 = pc + 8'd3;
    return {pc, b1, b2, b3};
  endfunction

  task automatic push_exp(input logic [7:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = exp_word(pc);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: any presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && !bus.redirect && bus.instr_valid) begin
      if (sb.size() == 0) begin
        if (bus.instr_ready) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %0h instr %0h, expected no word", bus.instr_pc,
                   bus.instr);
        end
      end else begin
        chk("sb_pc", 64'(bus.instr_pc), 64'(sb[0].pc));
        chk("sb_instr", 64'(bus.instr), 64'(sb[0].word));
        if (bus.instr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    tick();
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.instr_ready = rdy;
    sb.delete();
    @(negedge clk);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_rd", 64'(bus.imem_rd), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_pc", 64'(bus.instr_pc), 64'd0);
`ifdef IFU_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at a negedge: counts invalid cycles until the first valid word.
  task automatic latency(input string name, input int exp_n);
    int n = 0;
    while (!bus.instr_valid && n < 50) begin
      n++;
      tick();
      @(negedge clk);
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic drain(input string name);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    bus.instr_ready = 1'b0;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;

    for (int k = 0; k < 10; k++) begin
      tbl[k].ready     = 1'b1;
      tbl[k].exp_rd    = 1'b1;
      tbl[k].exp_addr  = 8'(k);
      tbl[k].exp_valid = (k == 5) || (k == 9);
      tbl[k].exp_instr = (k < 5) ? 32'h0 : (k < 9) ? 32'h00010203 : 32'h04050607;
      tbl[k].exp_pc    = (k == 9) ? 8'h04 : 8'h00;
    end

    // Cycle-by-cycle after reset with ready held high.
    do_reset(1'b1);
    push_exp(8'h00);
    push_exp(8'h04);
    for (int k = 0; k < 10; k++) begin
      bus.instr_ready = tbl[k].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd", k), 64'(bus.imem_rd), 64'(tbl[k].exp_rd));
      chk($sformatf("tbl%0d_addr", k), 64'(bus.imem_addr), 64'(tbl[k].exp_addr));
      chk($sformatf("tbl%0d_valid", k), 64'(bus.instr_valid), 64'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_instr", k), 64'(bus.instr), 64'(tbl[k].exp_instr));
      chk($sformatf("tbl%0d_pc", k), 64'(bus.instr_pc), 64'(tbl[k].exp_pc));
`ifdef IFU_STALL_CNT_EN
      if (k == 5) chk("stall_cnt_first_valid", 64'(stall_cnt), 64'd5);
`endif
      tick();
    end
    bus.instr_ready = 1'b0;

    // Backpressure: FIFO fills with pc 0 and 4, fetch stalls, then drains.
    do_reset(1'b0);
    push_exp(8'h00);
    push_exp(8'h04);
    push_exp(8'h08);
    repeat (14) tick();
    @(negedge clk);
    chk("full_rd", 64'(bus.imem_rd), 64'd0);
    chk("full_valid", 64'(bus.instr_valid), 64'd1);
    chk("full_pc", 64'(bus.instr_pc), 64'h00);
    tick();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("pop0_pc", 64'(bus.instr_pc), 64'h00);
    tick();
    @(negedge clk);
    chk("pop1_valid", 64'(bus.instr_valid), 64'd1);
    chk("pop1_pc", 64'(bus.instr_pc), 64'h04);
    tick();
    @(negedge clk);
    chk("resume_rd", 64'(bus.imem_rd), 64'd1);
    chk("resume_addr", 64'(bus.imem_addr), 64'h08);
    chk("resume_valid", 64'(bus.instr_valid), 64'd0);
    drain("drain_stall");

    // Redirect mid-word with a read outstanding.
    do_reset(1'b1);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h13;
    sb.delete();
    push_exp(8'h10);
    push_exp(8'h14);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid", 64'(bus.instr_valid), 64'd0);
    chk("redir_rd", 64'(bus.imem_rd), 64'd1);
    chk("redir_addr", 64'(bus.imem_addr), 64'h10);
`ifdef IFU_STALL_CNT_EN
    chk("redir_stall_cnt", 64'(stall_cnt), 64'd1);
`endif
    latency("redir_latency", 5);
    drain("drain_redir");

    // Redirect coinciding with a pop and a push: nothing stale may appear.
    do_reset(1'b0);
    push_exp(8'h00);
    repeat (8) tick();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    sb.delete();
    push_exp(8'h40);
    push_exp(8'h44);
    @(negedge clk);
    chk("pp_pre_valid", 64'(bus.instr_valid), 64'd1);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("pp_post_valid", 64'(bus.instr_valid), 64'd0);
    latency("pp_latency", 5);
    drain("drain_pp");

    // Wrap: word at 0xFC followed by word at 0x00.
    do_reset(1'b1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFC;
    push_exp(8'hFC);
    push_exp(8'h00);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("wrap_addr", 64'(bus.imem_addr), 64'hFC);
    latency("wrap_latency", 5);
    drain("drain_wrap");

    // Back-to-back redirects: the last one wins.
    do_reset(1'b1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    push_exp(8'h20);
    tick();
    bus.redirect_pc = 8'h31;
    sb.delete();
    push_exp(8'h30);
    push_exp(8'h34);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("b2b_addr", 64'(bus.imem_addr), 64'h30);
    latency("b2b_latency", 5);
    drain("drain_b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
